npu_spi_slave: RTL and testbench
================================

# npu_spi_slave

SPI mode-0 slave front end for the NPU system, running entirely in the `rpll_clk` domain. It sits directly downstream of the clock/reset generation and upstream of the NPU command/data path. It oversamples the external `sclk`/`mosi`/`cs_n` pins, assembles MSB-first bytes, and presents them on a valid/ready stream. In the same transfer it shifts response bytes out on `miso`.

## Interface
- `SYNC_STAGES`, default 2: flip-flop stages per input synchronizer. Must be ≥2.
- `IDLE_BYTE`, default 8'h00: byte shifted out when no TX byte is available (underflow).
- `rpll_clk` in 1: system clock, 47.25 MHz.
- `rst_n` in 1: reset, asynchronous, active-low.
- `sclk` in 1: SPI clock, asynchronous to `rpll_clk`. Maximum frequency is `rpll_clk`/8.
- `mosi` in 1: SPI data in, asynchronous.
- `cs_n` in 1: SPI chip select, active-low, asynchronous.
- `miso` out 1: SPI data out, registered.
- `rx_data` out 8: received byte.
- `rx_valid` out 1: `rx_data` holds an unconsumed byte.
- `rx_ready` in 1: consumer accepts `rx_data`.
- `rx_overrun` out 1: sticky flag, set when a byte was lost.
- `tx_data` in 8: next byte to transmit.
- `tx_valid` in 1: `tx_data` is available.
- `tx_ready` out 1: high exactly in a TX load cycle. The byte is taken when `tx_valid & tx_ready`.
- `frame_active` out 1: high while the FSM is in SHIFT.
- `frame_end` out 1: one-cycle pulse on `cs_n` deassertion after an aligned frame.
- `frame_abort` out 1: one-cycle pulse on `cs_n` deassertion with a partial byte pending.

## Operation
- Synchronization and edge detection
  - `sclk`, `mosi` and `cs_n` each pass through a SYNC_STAGES synchronizer, followed by one history flop.
  - `sclk_rise`, `sclk_fall`, `cs_fall` and `cs_rise` are detected from synchronized value versus history.
- FSM states
  - IDLE → SHIFT on `cs_fall`.
  - SHIFT → IDLE on `cs_rise`.
  - Edges on `sclk` are ignored in IDLE.
- Entering SHIFT
  - Clear the bit counter to 0.
  - Clear `rx_overrun`.
  - Perform a TX load.
- `sclk_rise` in SHIFT
  - Shift the synchronized `mosi` into the RX shift register LSB; increment the 3-bit bit counter.
  - When the counter wraps from 7 to 0, the completed byte goes to `rx_data` and `rx_valid` sets.
  - If `rx_valid` is already set and `rx_ready` is not asserted in that cycle: drop the new byte, keep the old one, and set `rx_overrun`.
  - If `rx_valid & rx_ready` coincide with a byte completion, the new byte replaces the old one with no overrun.
- `sclk_fall` in SHIFT
  - Shift the TX register left and drive its MSB to `miso`.
  - If it is the falling edge after the 8th rising edge (counter == 0 and at least one byte done), perform a TX load instead of the shift.
- TX load
  - `tx_ready`=1 for that cycle.
  - Load `tx_data` if `tx_valid`, otherwise load IDLE_BYTE.
  - `miso` takes bit 7 of the loaded byte on the next edge.
- `rx_valid` clears on `rx_valid & rx_ready` when no new byte completes in that cycle.
- `cs_rise`
  - Pulse `frame_end` if the counter is 0, or `frame_abort` if it is nonzero.
  - Discard partial RX bits; `rx_valid`/`rx_data` are unaffected.
  - `miso` returns to 0.
- `cs_n` high also discards any unused TX byte. No TX byte is consumed outside a load cycle.

## Timing
- Reset values:
  - `miso`=0, `rx_data`=0, `rx_valid`=0, `rx_overrun`=0, `tx_ready`=0.
  - `frame_active`=0, `frame_end`=0, `frame_abort`=0.
  - FSM in IDLE, all shift registers and counters 0.
- Pin-to-detect latency: SYNC_STAGES+1 `rpll_clk` cycles (3 at default).
- `rx_valid` rises 1 cycle after the detect cycle of the 8th `sclk_rise`.
- The first MSB is valid on `miso` 1 cycle after the `cs_fall` detect.
- Host requirements:
  - `cs_n` setup to the first `sclk` rise is ≥6 `rpll_clk` cycles.
  - `sclk` high and low times are each ≥4 `rpll_clk` cycles.
- Simultaneous `cs_rise` and `sclk_rise` in one cycle: `cs_rise` wins and the edge is ignored.
- `rst_n` asserted mid-frame: immediate return to reset values. After release, the FSM stays in IDLE until a fresh `cs_fall`. If `cs_n` is already low at release, no frame starts.

## Structure
- Package `npu_spi_pkg`:
  - `spi_state_t` enum with values IDLE and SHIFT.
  - `BYTE_W`=8 and `BIT_CNT_W`=3 constants.
- Sub-module `spi_sync_bit`: parameterized SYNC_STAGES synchronizer with reset value as a parameter. Instantiated three times; reset values are 0 for `sclk` and `mosi`, 1 for `cs_n`.
- Everything else (edge detect, FSM, RX/TX shifters, handshakes) lives in `npu_spi_slave`.

## Test plan
- Reset:
  - Stimulus: hold `rst_n` low with random pins.
  - Response: all outputs at their reset values; no pulses within 10 cycles after release while `cs_n`=1.
- Single byte:
  - Stimulus: host sends 0xA5 with `tx_data`=0x3C and `tx_valid`=1.
  - Response: `rx_data`=0xA5 with `rx_valid` set; host samples 0x3C; one `tx_ready` pulse at `cs_fall`; one `frame_end` pulse.
- Back-to-back with backpressure:
  - Stimulus: host sends 0x11, 0x22 with `rx_ready`=0.
  - Response: `rx_data` stays 0x11 and `rx_overrun`=1. The next `cs_fall` clears `rx_overrun`.
- TX underflow:
  - Stimulus: 2-byte frame with `tx_valid`=0.
  - Response: host samples 0x00, 0x00; two `tx_ready` load cycles occur.
- Abort:
  - Stimulus: `cs_n` rises after 5 `sclk` edges of byte 0x5A.
  - Response: `frame_abort` pulses once, `rx_valid` stays 0, and the next frame byte 0xC3 is received correctly.
- Reset mid-frame:
  - Stimulus: assert `rst_n` after bit 4 of a byte, release it while `cs_n`=0.
  - Response: no byte is received and no `frame_end`; `frame_active`=0 until the next `cs_fall`.

Source files
------------

// File: rtl/npu_spi_pkg.sv
// =============================================================================
// Module   : npu_spi_pkg
// Brief    : Shared state encoding and width constants for the NPU SPI slave.
// Revision : 1.0 - initial release
// =============================================================================
`timescale 1ns/1ps
`default_nettype none

package npu_spi_pkg;

  localparam int BYTE_W    = 8;
  localparam int BIT_CNT_W = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_t;

endpackage

`default_nettype wire

// File: rtl/spi_sync_bit.sv
// =============================================================================
// Module   : spi_sync_bit
// Brief    : Multi-stage synchronizer for one asynchronous pin, with a
//            parameterized reset value.
// Revision : 1.0 - initial release
// =============================================================================
`timescale 1ns/1ps
`default_nettype none

module spi_sync_bit #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic rpll_clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  // SYNC_STAGES must be at least 2 for the slice below to be well formed.
  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge rpll_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {SYNC_STAGES{RST_VAL}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/npu_spi_slave.sv
// =============================================================================
// Module   : npu_spi_slave
// Brief    : SPI mode-0 slave; oversamples sclk/mosi/cs_n in rpll_clk, presents
//            received bytes on a valid/ready stream and shifts responses on miso.
// Revision : 1.0 - initial release
// =============================================================================
`timescale 1ns/1ps
`default_nettype none

module npu_spi_slave
  import npu_spi_pkg::*;
#(
  parameter int                SYNC_STAGES = 2,
  parameter logic [BYTE_W-1:0] IDLE_BYTE   = 8'h00
) (
  input  logic              rpll_clk,
  input  logic              rst_n,
  input  logic              i_sclk,
  input  logic              i_mosi,
  input  logic              i_cs_n,
  output logic              o_miso,
  output logic [BYTE_W-1:0] o_rx_data,
  output logic              o_rx_valid,
  input  logic              i_rx_ready,
  output logic              o_rx_overrun,
  input  logic [BYTE_W-1:0] i_tx_data,
  input  logic              i_tx_valid,
  output logic              o_tx_ready,
  output logic              o_frame_active,
  output logic              o_frame_end,
  output logic              o_frame_abort
);

  logic w_sclk_s;
  logic w_mosi_s;
  logic w_cs_n_s;

  spi_sync_bit #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .rpll_clk (rpll_clk),
    .rst_n    (rst_n),
    .i_d      (i_sclk),
    .o_q      (w_sclk_s)
  );

  spi_sync_bit #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .rpll_clk (rpll_clk),
    .rst_n    (rst_n),
    .i_d      (i_mosi),
    .o_q      (w_mosi_s)
  );

  spi_sync_bit #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .rpll_clk (rpll_clk),
    .rst_n    (rst_n),
    .i_d      (i_cs_n),
    .o_q      (w_cs_n_s)
  );

  logic                   r_sclk_d;
  logic                   r_mosi_d;
  logic                   r_cs_n_d;
  logic [SYNC_STAGES-1:0] r_warm;
  logic                   r_armed;

  // A frame may only start once a genuine high level of cs_n has been seen
  // after reset; the synchronizer's reset value does not count.
  always_ff @(posedge rpll_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_d <= 1'b0;
      r_mosi_d <= 1'b0;
      r_cs_n_d <= 1'b1;
      r_warm   <= '0;
      r_armed  <= 1'b0;
    end else begin
      r_sclk_d <= w_sclk_s;
      r_mosi_d <= w_mosi_s;
      r_cs_n_d <= w_cs_n_s;
      r_warm   <= {r_warm[SYNC_STAGES-2:0], 1'b1};
      r_armed  <= r_armed | (r_warm[SYNC_STAGES-1] & w_cs_n_s);
    end
  end

  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_cs_fall;
  logic w_cs_rise;

  assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
  assign w_cs_fall   = ~w_cs_n_s & r_cs_n_d & r_armed;
  assign w_cs_rise   = w_cs_n_s & ~r_cs_n_d;

  spi_state_t             r_state;
  spi_state_t             w_state_nxt;
  logic [BIT_CNT_W-1:0]   r_bit_cnt;
  logic                   r_byte_done;
  logic                   w_enter;
  logic                   w_exit;
  logic                   w_tx_load;
  logic                   w_rx_shift;
  logic                   w_tx_shift;

  always_ff @(posedge rpll_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // cs_rise takes priority over any sclk edge detected in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_enter     = 1'b0;
    w_exit      = 1'b0;
    w_tx_load   = 1'b0;
    w_rx_shift  = 1'b0;
    w_tx_shift  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_cs_fall) begin
          w_state_nxt = SHIFT;
          w_enter     = 1'b1;
          w_tx_load   = 1'b1;
        end
      end
      SHIFT: begin
        if (w_cs_rise) begin
          w_state_nxt = IDLE;
          w_exit      = 1'b1;
        end else begin
          w_rx_shift = w_sclk_rise;
          if (w_sclk_fall) begin
            if ((r_bit_cnt == '0) && r_byte_done) begin
              w_tx_load = 1'b1;
            end else begin
              w_tx_shift = 1'b1;
            end
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  logic [BYTE_W-2:0] r_rx_sh;
  logic [BYTE_W-2:0] r_tx_sh;
  logic              r_miso;
  logic [BYTE_W-1:0] r_rx_data;
  logic              r_rx_valid;
  logic              r_overrun;
  logic              r_frame_end;
  logic              r_frame_abort;
  logic [BYTE_W-1:0] w_rx_byte;
  logic [BYTE_W-1:0] w_tx_byte;
  logic              w_byte_cmp;

  assign w_rx_byte  = {r_rx_sh, r_mosi_d};
  assign w_tx_byte  = i_tx_valid ? i_tx_data : IDLE_BYTE;
  assign w_byte_cmp = w_rx_shift & (r_bit_cnt == {BIT_CNT_W{1'b1}});

  always_ff @(posedge rpll_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt     <= '0;
      r_byte_done   <= 1'b0;
      r_rx_sh       <= '0;
      r_tx_sh       <= '0;
      r_miso        <= 1'b0;
      r_frame_end   <= 1'b0;
      r_frame_abort <= 1'b0;
    end else begin
      r_frame_end   <= w_exit & (r_bit_cnt == '0);
      r_frame_abort <= w_exit & (r_bit_cnt != '0);
      if (w_enter || w_exit) begin
        r_bit_cnt   <= '0;
        r_byte_done <= 1'b0;
        r_rx_sh     <= '0;
      end else if (w_rx_shift) begin
        r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
        r_rx_sh   <= w_rx_byte[BYTE_W-2:0];
        if (w_byte_cmp) begin
          r_byte_done <= 1'b1;
        end
      end
      // Only the low 7 bits are kept; bit 7 goes straight to miso on a load.
      if (w_exit) begin
        r_tx_sh <= '0;
        r_miso  <= 1'b0;
      end else if (w_tx_load) begin
        r_tx_sh <= w_tx_byte[BYTE_W-2:0];
        r_miso  <= w_tx_byte[BYTE_W-1];
      end else if (w_tx_shift) begin
        r_tx_sh <= {r_tx_sh[BYTE_W-3:0], 1'b0};
        r_miso  <= r_tx_sh[BYTE_W-2];
      end
    end
  end

  always_ff @(posedge rpll_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (w_enter) begin
        r_overrun <= 1'b0;
      end
      if (w_byte_cmp) begin
        if (r_rx_valid && !i_rx_ready) begin
          r_overrun <= 1'b1;
        end else begin
          r_rx_data  <= w_rx_byte;
          r_rx_valid <= 1'b1;
        end
      end else if (r_rx_valid && i_rx_ready) begin
        r_rx_valid <= 1'b0;
      end
    end
  end

  assign o_miso         = r_miso;
  assign o_rx_data      = r_rx_data;
  assign o_rx_valid     = r_rx_valid;
  assign o_rx_overrun   = r_overrun;
  assign o_tx_ready     = w_tx_load;
  assign o_frame_active = (r_state == SHIFT);
  assign o_frame_end    = r_frame_end;
  assign o_frame_abort  = r_frame_abort;

endmodule

`default_nettype wire

// File: tb/tb_npu_spi_slave.sv
// =============================================================================
// Module   : tb_npu_spi_slave
// Brief    : Self-checking bench for npu_spi_slave: directed and random frames.
// Revision : 1.0 - initial release
// =============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_npu_spi_slave;

  logic       rpll_clk = 1'b0;
  logic       rst_n;
  logic       i_sclk, i_mosi, i_cs_n;
  logic       o_miso;
  logic [7:0] o_rx_data;
  logic       o_rx_valid, i_rx_ready, o_rx_overrun;
  logic [7:0] i_tx_data;
  logic       i_tx_valid, o_tx_ready;
  logic       o_frame_active, o_frame_end, o_frame_abort;

  always #10 rpll_clk = ~rpll_clk;

  npu_spi_slave #(.SYNC_STAGES(2), .IDLE_BYTE(8'h00)) dut (
    .rpll_clk       (rpll_clk),
    .rst_n          (rst_n),
    .i_sclk         (i_sclk),
    .i_mosi         (i_mosi),
    .i_cs_n         (i_cs_n),
    .o_miso         (o_miso),
    .o_rx_data      (o_rx_data),
    .o_rx_valid     (o_rx_valid),
    .i_rx_ready     (i_rx_ready),
    .o_rx_overrun   (o_rx_overrun),
    .i_tx_data      (i_tx_data),
    .i_tx_valid     (i_tx_valid),
    .o_tx_ready     (o_tx_ready),
    .o_frame_active (o_frame_active),
    .o_frame_end    (o_frame_end),
    .o_frame_abort  (o_frame_abort)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge rpll_clk);
    #1;
  endtask

  // Monitors: pulse counters, accepted RX bytes, TX source queue.
  int         n_end, n_abort, n_load;
  logic [7:0] rx_got[$];
  logic [7:0] tx_q[$];
  bit         took;

  always @(negedge rpll_clk) begin
    if (rst_n === 1'b1) begin
      if (o_frame_end)             n_end++;
      if (o_frame_abort)           n_abort++;
      if (o_rx_valid && i_rx_ready) rx_got.push_back(o_rx_data);
    end
  end

  initial begin
    i_tx_valid = 1'b0;
    i_tx_data  = 8'h00;
    forever begin
      @(negedge rpll_clk);
      took = (rst_n === 1'b1) && o_tx_ready && i_tx_valid;
      if ((rst_n === 1'b1) && o_tx_ready) n_load++;
      @(posedge rpll_clk);
      #1;
      if (took && tx_q.size() > 0) void'(tx_q.pop_front());
      i_tx_valid = (tx_q.size() > 0);
      i_tx_data  = (tx_q.size() > 0) ? tx_q[0] : 8'($urandom);
    end
  end

  typedef struct {
    int               nb;     // full bytes in frame
    int               p;      // trailing partial bits
    logic [3:0][7:0]  mosi;
    logic [3:0][7:0]  txb;
    int               ntx;    // TX bytes offered before the frame
    bit               rdy;
    int               e_end, e_abort, e_ovr, e_loads;
  } vec_t;

  function automatic vec_t mk(input int nb, input int p, input logic [31:0] m,
                              input logic [31:0] t, input int ntx, input bit rdy,
                              input int ee, input int ea, input int eo, input int el);
    vec_t v;
    v.nb = nb; v.p = p; v.mosi = m; v.txb = t; v.ntx = ntx; v.rdy = rdy;
    v.e_end = ee; v.e_abort = ea; v.e_ovr = eo; v.e_loads = el;
    return v;
  endfunction

  // Reference rules: one load at frame start plus one after every full byte
  // that is followed by more clocks; overrun only when a second byte lands on
  // an unconsumed first one.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    int   l = v.nb + ((v.p > 0) ? 1 : 0);
    r.e_loads = (l < 1) ? 1 : l;
    r.e_end   = (v.p == 0) ? 1 : 0;
    r.e_abort = (v.p > 0) ? 1 : 0;
    r.e_ovr   = (!v.rdy && v.nb >= 2) ? 1 : 0;
    return r;
  endfunction

  task automatic run_frame(input vec_t v, input int idx);
    logic [3:0][7:0] samp;
    int              total;
    logic [7:0]      exp_b;
    samp = '0;
    i_rx_ready = v.rdy;
    rx_got.delete();
    for (int i = 0; i < v.ntx; i++) tx_q.push_back(v.txb[i]);
    cyc(3);
    n_end = 0; n_abort = 0; n_load = 0;
    i_cs_n = 1'b0;
    cyc(8);
    chk($sformatf("v%0d ovr_clear", idx), o_rx_overrun, 0);
    chk($sformatf("v%0d active", idx), o_frame_active, 1);
    total = v.nb * 8 + v.p;
    for (int b = 0; b < total; b++) begin
      i_sclk = 1'b0;
      i_mosi = v.mosi[b / 8][7 - (b % 8)];
      cyc(5);
      samp[b / 8][7 - (b % 8)] = o_miso;
      i_sclk = 1'b1;
      cyc(5);
    end
    i_sclk = 1'b0;
    i_cs_n = 1'b1;
    cyc(8);
    for (int i = 0; i < v.nb; i++) begin
      exp_b = (i < v.ntx) ? v.txb[i] : 8'h00;
      chk($sformatf("v%0d miso_byte%0d", idx, i), samp[i], exp_b);
    end
    chk($sformatf("v%0d frame_end", idx), n_end, v.e_end);
    chk($sformatf("v%0d frame_abort", idx), n_abort, v.e_abort);
    chk($sformatf("v%0d tx_loads", idx), n_load, v.e_loads);
    chk($sformatf("v%0d tx_left", idx), tx_q.size(), 0);
    chk($sformatf("v%0d overrun", idx), o_rx_overrun, v.e_ovr);
    if (v.rdy) begin
      chk($sformatf("v%0d rx_count", idx), rx_got.size(), v.nb);
      for (int i = 0; i < v.nb && i < rx_got.size(); i++)
        chk($sformatf("v%0d rx_byte%0d", idx, i), rx_got[i], v.mosi[i]);
    end else begin
      chk($sformatf("v%0d rx_valid_held", idx), o_rx_valid, (v.nb >= 1) ? 1 : 0);
      if (v.nb >= 1) chk($sformatf("v%0d rx_data_held", idx), o_rx_data, v.mosi[0]);
      i_rx_ready = 1'b1;
      cyc(3);
      chk($sformatf("v%0d drained", idx), rx_got.size(), (v.nb >= 1) ? 1 : 0);
    end
    chk($sformatf("v%0d rx_valid_idle", idx), o_rx_valid, 0);
    chk($sformatf("v%0d inactive", idx), o_frame_active, 0);
  endtask

  localparam int N_DIR = 6;
  localparam int N_VEC = N_DIR + 20;

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[N_VEC];
    int   l;

    // Reset with random pin activity.
    rst_n = 1'b0; i_sclk = 1'b0; i_mosi = 1'b0; i_cs_n = 1'b1; i_rx_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge rpll_clk); #1;
      i_sclk = 1'($urandom); i_mosi = 1'($urandom);
      i_cs_n = 1'($urandom); i_rx_ready = 1'($urandom);
    end
    chk("rst miso", o_miso, 0);
    chk("rst rx_data", o_rx_data, 0);
    chk("rst rx_valid", o_rx_valid, 0);
    chk("rst overrun", o_rx_overrun, 0);
    chk("rst tx_ready", o_tx_ready, 0);
    chk("rst active", o_frame_active, 0);
    chk("rst frame_end", o_frame_end, 0);
    chk("rst frame_abort", o_frame_abort, 0);
    i_sclk = 1'b0; i_cs_n = 1'b1; i_rx_ready = 1'b1;
    cyc(1);
    rst_n = 1'b1;
    n_end = 0; n_abort = 0; n_load = 0;
    cyc(10);
    chk("post_rst pulses", n_end + n_abort, 0);
    chk("post_rst loads", n_load, 0);
    chk("post_rst active", o_frame_active, 0);

    // Directed rows: single byte, backpressure+underflow, overrun clear,
    // abort, recovery byte, mixed TX availability.
    vecs[0] = mk(1, 0, 32'h0000_00A5, 32'h0000_003C, 1, 1, 1, 0, 0, 1);
    vecs[1] = mk(2, 0, 32'h0000_2211, 32'h0,         0, 0, 1, 0, 1, 2);
    vecs[2] = mk(2, 0, 32'h0000_F00F, 32'h0,         0, 1, 1, 0, 0, 2);
    vecs[3] = mk(0, 5, 32'h0000_005A, 32'h0,         0, 1, 0, 1, 0, 1);
    vecs[4] = mk(1, 0, 32'h0000_00C3, 32'h0000_0096, 1, 1, 1, 0, 0, 1);
    vecs[5] = mk(3, 0, 32'h00FF_8001, 32'h0000_3412, 2, 1, 1, 0, 0, 3);
    for (int i = N_DIR; i < N_VEC; i++) begin
      vec_t v;
      v.nb   = $urandom_range(0, 4);
      v.p    = (v.nb == 0 || (v.nb < 4 && $urandom_range(0, 3) == 0)) ? $urandom_range(1, 7) : 0;
      v.mosi = {$urandom};
      v.txb  = {$urandom};
      v.rdy  = 1'($urandom);
      l      = v.nb + ((v.p > 0) ? 1 : 0);
      if (l < 1) l = 1;
      v.ntx  = $urandom_range(0, l);
      vecs[i] = model(v);
    end

    // Reset mid-frame, released with cs_n still low.
    rx_got.delete();
    i_cs_n = 1'b0;
    cyc(8);
    for (int b = 0; b < 4; b++) begin
      i_sclk = 1'b0; i_mosi = 1'($urandom); cyc(5);
      i_sclk = 1'b1; cyc(5);
    end
    i_sclk = 1'b0;
    rst_n = 1'b0;
    cyc(3);
    chk("midrst active", o_frame_active, 0);
    rst_n = 1'b1;
    n_end = 0; n_abort = 0; n_load = 0;
    cyc(10);
    for (int b = 0; b < 8; b++) begin
      i_sclk = 1'b0; i_mosi = 1'($urandom); cyc(5);
      i_sclk = 1'b1; cyc(5);
    end
    i_sclk = 1'b0;
    cyc(6);
    chk("midrst active_after", o_frame_active, 0);
    chk("midrst rx_valid", o_rx_valid, 0);
    chk("midrst rx_count", rx_got.size(), 0);
    chk("midrst loads", n_load, 0);
    i_cs_n = 1'b1;
    cyc(10);
    chk("midrst frame_end", n_end, 0);
    chk("midrst frame_abort", n_abort, 0);

    for (int i = 0; i < N_VEC; i++) run_frame(vecs[i], i);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
